// File: rtl/bubsys_prog_wrbuf_if.sv
// ---------------------------------------------------------------------------
// bubsys_prog_wrbuf_if
//   SDRAM programming-port handshake between the ROM write buffer (master)
//   and the SDRAM controller (slave).
//
//   prog_wr    master->slave  write request, level, held until prog_ack
//   prog_addr  master->slave  SDRAM word address (AW bits)
//   prog_ba    master->slave  SDRAM bank
//   prog_din   master->slave  16-bit data, byte replicated on both lanes
//   prog_mask  master->slave  byte lane mask
//   prog_ack   slave->master  one-cycle acknowledge
// ---------------------------------------------------------------------------
interface bubsys_prog_wrbuf_if #(
    parameter int unsigned AW = 22
);
    logic          prog_wr;
    logic [AW-1:0] prog_addr;
    logic [1:0]    prog_ba;
    logic [15:0]   prog_din;
    logic [1:0]    prog_mask;
    logic          prog_ack;

    modport master (
        output prog_wr,
        output prog_addr,
        output prog_ba,
        output prog_din,
        output prog_mask,
        input  prog_ack
    );

    modport slave (
        input  prog_wr,
        input  prog_addr,
        input  prog_ba,
        input  prog_din,
        input  prog_mask,
        output prog_ack
    );
endinterface

// File: rtl/bubsys_prog_wrbuf.sv
// ---------------------------------------------------------------------------
// bubsys_prog_wrbuf
//   Write buffer between the ioctl byte stream and the SDRAM programming port.
//   Already-mapped byte writes are queued in a small FIFO and issued one at a
//   time on the prog_wr/prog_ack handshake. o_WAIT throttles the HPS so the
//   SDRAM path never stalls the ioctl bus per byte.
//
//   i_EMU_MCLK       system clock, rising edge
//   i_EMU_INITRST_n  asynchronous active-low reset
//   i_EN             SDRAM-region download active (gates pushes only)
//   i_WR             byte write strobe, one cycle per byte
//   i_ADDR/i_BA      mapped SDRAM word address / bank
//   i_MASK/i_DATA    byte lane (01 = hi, 10 = lo) / byte payload
//   i_SDRAM_INIT     controller still initialising; blocks issue
//   o_WAIT           ioctl_wait request to HPS
//   o_EMPTY          FIFO empty and no write outstanding
//   o_OVERFLOW       sticky: a byte was dropped
//   prog             programming port (master side)
// ---------------------------------------------------------------------------
module bubsys_prog_wrbuf #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned AW         = 22
) (
    input  logic                       i_EMU_MCLK,
    input  logic                       i_EMU_INITRST_n,
    input  logic                       i_EN,
    input  logic                       i_WR,
    input  logic [AW-1:0]              i_ADDR,
    input  logic [1:0]                 i_BA,
    input  logic [1:0]                 i_MASK,
    input  logic [7:0]                 i_DATA,
    input  logic                       i_SDRAM_INIT,
    output logic                       o_WAIT,
    output logic                       o_EMPTY,
    output logic                       o_OVERFLOW,
    bubsys_prog_wrbuf_if.master        prog
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned EW    = AW + 12;

    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    // Two slots of headroom for the HPS to react to o_WAIT.
    localparam logic [DEPTH_LOG2:0]   CNT_WAIT = (DEPTH_LOG2 + 1)'(DEPTH - 2);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    // Entry layout: {ba, addr, mask, data}
    logic [EW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    state_e                state_q;

    logic                  prog_wr_q;
    logic [AW-1:0]         prog_addr_q;
    logic [1:0]            prog_ba_q;
    logic [15:0]           prog_din_q;
    logic [1:0]            prog_mask_q;
    logic                  overflow_q;

    logic                  wr_req;
    logic                  pop;
    logic                  push;
    logic [EW-1:0]         head;
    logic [1:0]            head_ba;
    logic [AW-1:0]         head_addr;
    logic [1:0]            head_mask;
    logic [7:0]            head_data;

    assign wr_req = i_WR & i_EN;
    assign pop    = (state_q == StIdle) & (count_q != '0) & ~i_SDRAM_INIT;
    // A slot freed by this cycle's pop can take the incoming byte.
    assign push   = wr_req & ((count_q != CNT_FULL) | pop);

    assign head      = mem[rd_ptr_q];
    assign head_data = head[7:0];
    assign head_mask = head[9:8];
    assign head_addr = head[AW+9:10];
    assign head_ba   = head[AW+11:AW+10];

    assign o_WAIT     = i_SDRAM_INIT | (count_q >= CNT_WAIT);
    assign o_EMPTY    = (count_q == '0) & (state_q == StIdle);
    assign o_OVERFLOW = overflow_q;

    assign prog.prog_wr   = prog_wr_q;
    assign prog.prog_addr = prog_addr_q;
    assign prog.prog_ba   = prog_ba_q;
    assign prog.prog_din  = prog_din_q;
    assign prog.prog_mask = prog_mask_q;

    // Storage needs no reset: only slots below count_q are ever read.
    always_ff @(posedge i_EMU_MCLK) begin
        if (push) begin
            mem[wr_ptr_q] <= {i_BA, i_ADDR, i_MASK, i_DATA};
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            prog_wr_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_ba_q   <= 2'b00;
            prog_din_q  <= 16'hFFFF;
            prog_mask_q <= 2'b00;
            overflow_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
            if (wr_req && !push) begin
                overflow_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        prog_addr_q <= head_addr;
                        prog_ba_q   <= head_ba;
                        prog_din_q  <= {head_data, head_data};
                        prog_mask_q <= head_mask;
                        prog_wr_q   <= 1'b1;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    // Outstanding write completes regardless of i_SDRAM_INIT / i_EN.
                    if (prog.prog_ack) begin
                        prog_wr_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bubsys_prog_wrbuf.sv
`timescale 1ns/1ps
module tb_bubsys_prog_wrbuf;

    localparam int unsigned DEPTH_LOG2 = 3;
    localparam int unsigned AW         = 22;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned N_STREAM   = 32'h2000;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          en    = 1'b0;
    logic          wr    = 1'b0;
    logic          init  = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [1:0]    ba    = 2'b00;
    logic [1:0]    mask  = 2'b01;
    logic [7:0]    data  = 8'h00;
    logic          ack_man  = 1'b0;
    logic          ack_auto = 1'b0;
    logic          o_wait;
    logic          o_empty;
    logic          o_ovf;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_writes = 0;

    bubsys_prog_wrbuf_if #(.AW(AW)) pif ();
    assign pif.prog_ack = ack_man | ack_auto;

    bubsys_prog_wrbuf #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .AW         (AW)
    ) dut (
        .i_EMU_MCLK      (clk),
        .i_EMU_INITRST_n (rst_n),
        .i_EN            (en),
        .i_WR            (wr),
        .i_ADDR          (addr),
        .i_BA            (ba),
        .i_MASK          (mask),
        .i_DATA          (data),
        .i_SDRAM_INIT    (init),
        .o_WAIT          (o_wait),
        .o_EMPTY         (o_empty),
        .o_OVERFLOW      (o_ovf),
        .prog            (pif)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: a queue of pending bytes plus the one in flight.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]    ba;
        logic [AW-1:0] addr;
        logic [1:0]    mask;
        logic [7:0]    data;
    } ent_t;

    ent_t mq[$];
    ent_t sb[$];
    ent_t m_cur;
    ent_t m_new;
    bit   m_busy = 1'b0;
    bit   m_have = 1'b0;
    bit   m_ovf  = 1'b0;
    bit   m_pop;
    bit   m_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            m_busy = 1'b0;
            m_have = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = !m_busy && (mq.size() != 0) && !init;
            if (m_busy) begin
                if (pif.prog_ack) m_busy = 1'b0;
            end else if (m_pop) begin
                m_cur  = mq.pop_front();
                m_busy = 1'b1;
                m_have = 1'b1;
            end
            if (wr && en) begin
                if (!m_full || m_pop) begin
                    m_new = {ba, addr, mask, data};
                    mq.push_back(m_new);
                    sb.push_back(m_new);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare plus in-order scoreboard of issued writes.
    logic          prev_wr = 1'b0;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_ba;
    logic [15:0]   e_din;
    logic [1:0]    e_mask;
    logic          e_empty;
    logic          e_wait;
    ent_t          sb_e;

    always @(negedge clk) begin
        e_addr  = m_have ? m_cur.addr : '0;
        e_ba    = m_have ? m_cur.ba : 2'b00;
        e_din   = m_have ? {m_cur.data, m_cur.data} : 16'hFFFF;
        e_mask  = m_have ? m_cur.mask : 2'b00;
        e_empty = (mq.size() == 0) && !m_busy;
        e_wait  = init || (mq.size() >= DEPTH - 2);
        n_tests++;
        if (pif.prog_wr !== m_busy || pif.prog_addr !== e_addr || pif.prog_ba !== e_ba ||
            pif.prog_din !== e_din || pif.prog_mask !== e_mask || o_empty !== e_empty ||
            o_wait !== e_wait || o_ovf !== m_ovf) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t dut/model wr %b/%b addr %h/%h ba %h/%h din %h/%h mask %b/%b empty %b/%b wait %b/%b ovf %b/%b",
                     $time, pif.prog_wr, m_busy, pif.prog_addr, e_addr, pif.prog_ba, e_ba,
                     pif.prog_din, e_din, pif.prog_mask, e_mask, o_empty, e_empty,
                     o_wait, e_wait, o_ovf, m_ovf);
        end
        if (pif.prog_wr === 1'b1 && prev_wr !== 1'b1) begin
            n_tests++;
            n_writes++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_order t=%0t write issued with nothing expected", $time);
            end else begin
                sb_e = sb.pop_front();
                if (pif.prog_addr !== sb_e.addr || pif.prog_ba !== sb_e.ba ||
                    pif.prog_mask !== sb_e.mask || pif.prog_din !== {sb_e.data, sb_e.data}) begin
                    n_fail++;
                    $display("FAIL sb_order t=%0t got addr %h ba %h mask %b din %h need addr %h ba %h mask %b data %h",
                             $time, pif.prog_addr, pif.prog_ba, pif.prog_mask, pif.prog_din,
                             sb_e.addr, sb_e.ba, sb_e.mask, sb_e.data);
                end
            end
        end
        prev_wr = pif.prog_wr;
    end

    // Controller emulation: ack 1..8 cycles after prog_wr rises.
    bit auto_on = 1'b0;
    int ack_cnt = 0;
    always @(posedge clk) begin
        #1;
        ack_auto = 1'b0;
        if (auto_on && pif.prog_wr === 1'b1) begin
            if (ack_cnt == 0) ack_auto = 1'b1;
            else ack_cnt--;
        end else begin
            ack_cnt = $urandom_range(0, 7);
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [AW-1:0] a, input logic [1:0] b,
                             input logic [1:0] m, input logic [7:0] d);
        wr = 1'b1; addr = a; ba = b; mask = m; data = d;
        step();
        wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr = 1'b0; en = 1'b0; init = 1'b0; ack_man = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [7:0] got[$];
    task automatic drain();
        got.delete();
        for (int c = 0; c < 300 && !o_empty; c++) begin
            if (pif.prog_wr) begin
                got.push_back(pif.prog_din[7:0]);
                ack_man = 1'b1;
                step();
                ack_man = 1'b0;
            end else begin
                step();
            end
        end
        chk("drain_done", {31'd0, o_empty}, 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int sent;
    int cyc;
    int w0;

    initial begin
        #2;
        // Reset values; o_WAIT follows i_SDRAM_INIT.
        do_reset();
        chk("rst_wr", {31'd0, pif.prog_wr}, 32'd0);
        chk("rst_empty", {31'd0, o_empty}, 32'd1);
        chk("rst_din", {16'd0, pif.prog_din}, 32'hFFFF);
        chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
        chk("rst_wait", {31'd0, o_wait}, 32'd0);
        init = 1'b1;
        #1;
        chk("rst_wait_init", {31'd0, o_wait}, 32'd1);
        init = 1'b0;

        // 1: single byte
        en = 1'b1;
        push_byte(22'h00123, 2'b00, 2'b01, 8'hA5);
        chk("t1_wr_after_push", {31'd0, pif.prog_wr}, 32'd0);
        chk("t1_not_empty", {31'd0, o_empty}, 32'd0);
        step();
        chk("t1_wr", {31'd0, pif.prog_wr}, 32'd1);
        chk("t1_din", {16'd0, pif.prog_din}, 32'hA5A5);
        chk("t1_addr", {10'd0, pif.prog_addr}, 32'h00123);
        chk("t1_mask", {30'd0, pif.prog_mask}, 32'd1);
        step();
        step();
        chk("t1_wr_held", {31'd0, pif.prog_wr}, 32'd1);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("t1_wr_dropped", {31'd0, pif.prog_wr}, 32'd0);
        chk("t1_empty", {31'd0, o_empty}, 32'd1);
        step();
        chk("t1_single", {31'd0, pif.prog_wr}, 32'd0);

        // 2: SDRAM init blocks issue; stray ack in idle ignored
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        init = 1'b1;
        push_byte(22'h00200, 2'b01, 2'b10, 8'h11);
        push_byte(22'h00201, 2'b10, 2'b01, 8'h22);
        chk("t2_wait", {31'd0, o_wait}, 32'd1);
        step();
        step();
        chk("t2_no_wr", {31'd0, pif.prog_wr}, 32'd0);
        init = 1'b0;
        step();
        chk("t2_first_wr", {31'd0, pif.prog_wr}, 32'd1);
        chk("t2_first_din", {16'd0, pif.prog_din}, 32'h1111);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        step();
        chk("t2_second_din", {16'd0, pif.prog_din}, 32'h2222);
        chk("t2_second_ba", {30'd0, pif.prog_ba}, 32'd2);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("t2_empty", {31'd0, o_empty}, 32'd1);

        // 3: stalled ack, wait threshold, overflow, order
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 6; i++) push_byte(22'(i), 2'b00, 2'b01, 8'(8'h10 + i));
        chk("t3_wait_low_cnt5", {31'd0, o_wait}, 32'd0);
        push_byte(22'd7, 2'b00, 2'b01, 8'h17);
        chk("t3_wait_high_cnt6", {31'd0, o_wait}, 32'd1);
        push_byte(22'd8, 2'b00, 2'b01, 8'h18);
        push_byte(22'd9, 2'b00, 2'b01, 8'h19);
        chk("t3_no_ovf_full", {31'd0, o_ovf}, 32'd0);
        push_byte(22'd10, 2'b00, 2'b01, 8'h1A);
        chk("t3_ovf", {31'd0, o_ovf}, 32'd1);
        drain();
        chk("t3_count", got.size(), 32'd9);
        for (int j = 0; j < 9 && j < got.size(); j++) chk("t3_order", {24'd0, got[j]}, 32'(8'h11 + j));
        chk("t3_ovf_sticky", {31'd0, o_ovf}, 32'd1);

        // 4: full FIFO, push on the pop edge right after ack
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 9; i++) push_byte(22'(i), 2'b01, 2'b10, 8'(8'h30 + i));
        chk("t4_wait_full", {31'd0, o_wait}, 32'd1);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        push_byte(22'h3A, 2'b01, 2'b10, 8'h3A);
        chk("t4_no_ovf", {31'd0, o_ovf}, 32'd0);
        chk("t4_next_din", {16'd0, pif.prog_din}, 32'h3232);
        drain();
        chk("t4_count", got.size(), 32'd9);
        for (int j = 0; j < 9 && j < got.size(); j++) chk("t4_order", {24'd0, got[j]}, 32'(8'h32 + j));
        chk("t4_no_ovf_end", {31'd0, o_ovf}, 32'd0);

        // 5: async reset while busy with 4 queued
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 5; i++) push_byte(22'(i), 2'b00, 2'b01, 8'(8'h50 + i));
        chk("t5_busy", {31'd0, pif.prog_wr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_async", {31'd0, pif.prog_wr}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t5_empty", {31'd0, o_empty}, 32'd1);
        chk("t5_din", {16'd0, pif.prog_din}, 32'hFFFF);
        step();
        step();
        chk("t5_no_wr", {31'd0, pif.prog_wr}, 32'd0);

        // 6: random stream honouring o_WAIT, random ack delay
        do_reset();
        auto_on = 1'b1;
        w0 = n_writes;
        sent = 0;
        cyc = 0;
        while (sent < N_STREAM && cyc < 80000) begin
            if (!o_wait && $urandom_range(0, 3) != 0) begin
                en   = ($urandom_range(0, 31) != 0);
                wr   = 1'b1;
                addr = 22'($urandom);
                ba   = 2'($urandom_range(0, 3));
                mask = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
                data = 8'($urandom);
                if (en) sent++;
            end else begin
                wr = 1'b0;
            end
            step();
            cyc++;
        end
        wr = 1'b0;
        chk("t6_stream_sent", sent, N_STREAM);
        for (int c = 0; c < 200 && !o_empty; c++) step();
        chk("t6_empty", {31'd0, o_empty}, 32'd1);
        chk("t6_writes", n_writes - w0, N_STREAM);
        chk("t6_sb_drained", sb.size(), 32'd0);
        chk("t6_no_ovf", {31'd0, o_ovf}, 32'd0);
        auto_on = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
